// File: rtl/bas_accumulator_4_bit.sv
// Sequential 4-bit signed accumulator driving binaryAdderSubtractor_4_bit through an IDLE/EXEC/RESP handshake.
// Optional build macro BAS_ACC_SATURATE_EN clamps acc to +7/-8 on overflow; flags still report raw adder C/V.

module binaryAdderSubtractor_4_bit (
  output logic [3:0] S,
  output logic       C,
  output logic       V,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M
);
  logic [3:0] b_eff;
  logic [4:0] sum;

  always_comb begin
    b_eff = B ^ {4{M}};
    sum   = {1'b0, A} + {1'b0, b_eff} + {4'b0000, M};
    S     = sum[3:0];
    C     = sum[4];
    V     = (A[3] == b_eff[3]) && (sum[3] != A[3]);
  end
endmodule

module bas_accumulator_4_bit #(
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [3:0]       in_data,
  input  logic                    in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [3:0]       acc,
  output logic                    acc_c,
  output logic                    acc_v,
  output logic                    ovf_sticky,
  output logic [CNT_W-1:0]        op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, next_state;
  logic signed [3:0]  operand_p0;
  logic               op_p0;
  logic        [3:0]  sum_s;
  logic               sum_c;
  logic               sum_v;

  binaryAdderSubtractor_4_bit u_addsub (
    .S(sum_s),
    .C(sum_c),
    .V(sum_v),
    .A(acc),
    .B(operand_p0),
    .M(op_p0)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + 1'b1;
  endfunction

`ifdef BAS_ACC_SATURATE_EN
  // Direction of overflow follows the sign of the operand the adder actually saw.
  function automatic logic signed [3:0] saturate(input logic [3:0] s, input logic v,
                                                 input logic b_msb);
    if (!v) return s;
    return b_msb ? 4'sb1000 : 4'sb0111;
  endfunction
`endif

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state      <= IDLE;
      operand_p0 <= '0;
      op_p0      <= 1'b0;
      acc        <= '0;
      acc_c      <= 1'b0;
      acc_v      <= 1'b0;
      ovf_sticky <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= next_state;
      // p0: operand capture on the accepting edge
      if (state == IDLE && in_valid) begin
        operand_p0 <= in_data;
        op_p0      <= in_op;
      end
      // EXEC edge: commit adder result and flags
      if (state == EXEC) begin
`ifdef BAS_ACC_SATURATE_EN
        acc <= saturate(sum_s, sum_v, operand_p0[3] ^ op_p0);
`else
        acc <= sum_s;
`endif
        acc_c      <= sum_c;
        acc_v      <= sum_v;
        ovf_sticky <= ovf_sticky | sum_v;
        op_count   <= sat_inc(op_count);
      end
    end
  end
endmodule

// File: doc/bas_accumulator_4_bit.md
Name: bas_accumulator_4_bit

Overview:
Sequential 4-bit signed accumulator built around the team's existing binaryAdderSubtractor_4_bit (port order S, C, V, A, B, M; M=0 add, M=1 subtract).
- Accepts one signed operand plus an add/sub opcode per valid/ready transaction.
- Drives the adder-subtractor with A=acc, B=operand, M=op.
- Registers result, carry and overflow, then presents them through an output handshake.
- Sits directly upstream of the adder-subtractor as its operand driver, and downstream as the capture stage for its S/C/V outputs.

Parameters:
- CNT_W, 8, width of the completed-operation counter op_count.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous soft clear of accumulator, flags, counter and FSM.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept operand.
- in_data  input  4  signed operand (two's complement).
- in_op  input  1  0 = acc + in_data, 1 = acc - in_data.
- out_valid  output  1  result in acc/acc_c/acc_v is new and held.
- out_ready  input  1  consumer accepts result.
- acc  output  4  signed accumulator value.
- acc_c  output  1  adder carry-out of last operation (subtract: 1 = no borrow).
- acc_v  output  1  signed overflow of last operation.
- ovf_sticky  output  1  OR of all acc_v since last rst/clr.
- op_count  output  CNT_W  completed operations, saturating.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE; acc, acc_c, acc_v, ovf_sticky, op_count, out_valid = 0; internal operand/op registers = 0; in_ready = 1 in the first cycle after reset.
- Priority: rst > clr > handshakes.
- clr has the same effect as rst on every register. It aborts any in-flight operation from any state. in_valid coincident with clr is not accepted.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: capture in_data and in_op into the operand registers, go to EXEC.
- EXEC:
  - in_ready = 0.
  - Adder-subtractor is combinationally fed A=acc, B=operand reg, M=op reg.
  - At the edge: acc <= S, acc_c <= C, acc_v <= V, ovf_sticky <= ovf_sticky | V, op_count <= op_count + 1 (holds at all-ones, no wrap). Go to RESP.
- RESP:
  - out_valid = 1; acc and the flags are held stable.
  - On out_valid & out_ready: go to IDLE.
  - out_ready is ignored in every other state.
- Latency: accept at edge k; acc updated and out_valid = 1 after edge k+1. If out_ready is already high, return to IDLE after edge k+2.
- Throughput: at most one operation every 3 cycles. No input/output overlap.
- Arithmetic: 4-bit two's complement; wrap on overflow (range -8..+7). Carry and overflow are taken unmodified from the adder-subtractor.
- Backpressure: while in RESP with out_ready = 0, in_ready stays 0 and an offered in_data is not consumed.
- in_data and in_op are sampled only at the accepting edge. Later changes do not affect the in-flight operation.
- The adder-subtractor instance is always driven; acc, flags and op_count change only at the EXEC edge.

Optional Feature:
Macro BAS_ACC_SATURATE_EN.
- Defined: when V=1 at the EXEC edge, acc <= +7 if the true result is positive overflow, -8 if negative overflow. Overflow direction = MSB of the operand as presented to the adder (after inversion for subtract). acc_v, acc_c and ovf_sticky still report the raw adder C/V.
- Undefined: acc <= S (wrap). Port list is identical in both builds.

Test Plan:
- rst; send add 3, then add 4 -> acc=7, acc_c=0, acc_v=0, op_count=2, out_valid asserted 2 edges after each accept.
- acc=7, add 1 -> acc=-8 (wrap build) / +7 (BAS_ACC_SATURATE_EN), acc_v=1, acc_c=0, ovf_sticky=1; then add 0 -> acc_v=0, ovf_sticky stays 1.
- clr; sub 1 -> acc=-1, acc_c=0; clr; add 5, sub 3 -> acc=2, acc_c=1, acc_v=0.
- acc=-8, sub 1 -> acc=7, acc_c=1, acc_v=1 (wrap build) / acc=-8 (saturate build).
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid stays 1, in_ready=0, acc unchanged, op_count unchanged; release -> next operand accepted the cycle after IDLE is re-entered.
- Assert rst (and separately clr) in EXEC and in RESP -> next cycle all outputs 0, in_ready=1, no result emitted; op_count reaching 2^CNT_W-1 holds there on further operations.
